// File: rtl/gyro_pkg.sv
// Shared types and defaults for the tilt/rate datapath blocks.
package gyro_pkg;

    localparam int WIDTH_DEF = 16;

    typedef enum logic [2:0] {
        PRIME,
        IDLE,
        CALC_X,
        CALC_Y,
        CALC_Z,
        HOLD
    } rate_state_t;

    typedef enum logic [1:0] {
        AX_X,
        AX_Y,
        AX_Z
    } axis_t;

    // Axis worked on by the shared subtractor in a given state.
    function automatic axis_t axis_of(input rate_state_t s);
        axis_t a;
        a = AX_X;
        case (s)
            CALC_Y:  a = AX_Y;
            CALC_Z:  a = AX_Z;
            default: a = AX_X;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/rate_diff_unit.sv
// Combinational modular difference of two tilt samples, scaled by an
// arithmetic right shift (floor toward minus infinity).
module rate_diff_unit #(
    parameter int WIDTH      = 16,
    parameter int RATE_SHIFT = 3
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] prev,
    output logic [WIDTH-1:0] rate
);

    logic signed [WIDTH-1:0] diff;

    // Wrapping subtraction read as signed, then scaled.
    always_comb begin
        diff = cur - prev;
        rate = diff >>> RATE_SHIFT;
    end

endmodule

// File: rtl/tilt_rate_estimator.sv
// Reconstructs per-axis angular rate from consecutive tilt samples using a
// single time-multiplexed subtractor, with valid/ready on both sides.
module tilt_rate_estimator
    import gyro_pkg::*;
#(
    parameter int WIDTH          = WIDTH_DEF,
    parameter int RATE_SHIFT     = 3,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] tilt_x,
    input  logic [WIDTH-1:0] tilt_y,
    input  logic [WIDTH-1:0] tilt_z,
    input  logic             tilt_valid,
    output logic             tilt_ready,
    output logic [WIDTH-1:0] dx,
    output logic [WIDTH-1:0] dy,
    output logic [WIDTH-1:0] dz,
    output logic             rate_valid,
    input  logic             rate_ready
);

    localparam int GAP_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST =
        (TIMEOUT_CYCLES > 0) ? GAP_W'(TIMEOUT_CYCLES - 1) : '0;

    rate_state_t state, state_nx;
    axis_t       axis;

    logic             accept;
    logic             timeout;
    logic [GAP_W-1:0] gap_cnt;

    logic [WIDTH-1:0] prev_x, prev_y, prev_z;
    logic [WIDTH-1:0] cur_x, cur_y, cur_z;
    logic [WIDTH-1:0] sh_x, sh_y;
    logic [WIDTH-1:0] mux_cur, mux_prev;
    logic [WIDTH-1:0] rate;

    // Handshake, timeout detect and next-state selection.
    always_comb begin
        state_nx   = state;
        tilt_ready = (state == PRIME) || (state == IDLE);
        accept     = tilt_valid && tilt_ready;
        timeout    = (TIMEOUT_CYCLES > 0) && (gap_cnt == GAP_LAST);
        axis       = axis_of(state);
        case (state)
            PRIME:   if (accept) state_nx = IDLE;
            IDLE: begin
                if (accept)       state_nx = CALC_X;
                else if (timeout) state_nx = PRIME;
            end
            CALC_X:  state_nx = CALC_Y;
            CALC_Y:  state_nx = CALC_Z;
            CALC_Z:  state_nx = HOLD;
            HOLD:    if (rate_ready) state_nx = IDLE;
            default: state_nx = PRIME;
        endcase
    end

    // Operand selection for the shared subtractor.
    always_comb begin
        mux_cur  = cur_x;
        mux_prev = prev_x;
        case (axis)
            AX_Y: begin
                mux_cur  = cur_y;
                mux_prev = prev_y;
            end
            AX_Z: begin
                mux_cur  = cur_z;
                mux_prev = prev_z;
            end
            default: begin
                mux_cur  = cur_x;
                mux_prev = prev_x;
            end
        endcase
    end

    rate_diff_unit #(
        .WIDTH      (WIDTH),
        .RATE_SHIFT (RATE_SHIFT)
    ) u_diff (
        .cur  (mux_cur),
        .prev (mux_prev),
        .rate (rate)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) state <= PRIME;
        else     state <= state_nx;
    end

    // Sample registers, gap counter, shadow results and output registers.
    // The Z result goes straight to dz on the CALC_Z edge, so no Z shadow exists.
    always_ff @(posedge CLK) begin
        if (RST) begin
            prev_x     <= '0;
            prev_y     <= '0;
            prev_z     <= '0;
            cur_x      <= '0;
            cur_y      <= '0;
            cur_z      <= '0;
            sh_x       <= '0;
            sh_y       <= '0;
            dx         <= '0;
            dy         <= '0;
            dz         <= '0;
            rate_valid <= 1'b0;
            gap_cnt    <= '0;
        end else begin
            case (state)
                PRIME: begin
                    gap_cnt <= '0;
                    if (accept) begin
                        prev_x <= tilt_x;
                        prev_y <= tilt_y;
                        prev_z <= tilt_z;
                    end
                end
                IDLE: begin
                    if (accept) begin
                        cur_x   <= tilt_x;
                        cur_y   <= tilt_y;
                        cur_z   <= tilt_z;
                        gap_cnt <= '0;
                    end else if (TIMEOUT_CYCLES > 0) begin
                        gap_cnt <= timeout ? '0 : gap_cnt + 1'b1;
                    end
                end
                CALC_X: sh_x <= rate;
                CALC_Y: sh_y <= rate;
                CALC_Z: begin
                    prev_x     <= cur_x;
                    prev_y     <= cur_y;
                    prev_z     <= cur_z;
                    dx         <= sh_x;
                    dy         <= sh_y;
                    dz         <= rate;
                    rate_valid <= 1'b1;
                end
                HOLD: if (rate_ready) rate_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tilt_rate_estimator.sv
// Directed bench for tilt_rate_estimator with an arithmetic reference model.
module tb_tilt_rate_estimator;

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] tilt_x, tilt_y, tilt_z;
    logic        tilt_valid;
    logic        tilt_ready;
    logic [15:0] dx, dy, dz;
    logic        rate_valid;
    logic        rate_ready;

    int total = 0;
    int bad   = 0;
    bit started = 0;

    tilt_rate_estimator #(
        .WIDTH          (16),
        .RATE_SHIFT     (3),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .tilt_x     (tilt_x),
        .tilt_y     (tilt_y),
        .tilt_z     (tilt_z),
        .tilt_valid (tilt_valid),
        .tilt_ready (tilt_ready),
        .dx         (dx),
        .dy         (dy),
        .dz         (dz),
        .rate_valid (rate_valid),
        .rate_ready (rate_ready)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: modular difference, signed reinterpretation, floor divide by 8.
    function automatic logic [15:0] ref_rate(input int cur, input int prev);
        int d;
        d = (cur - prev + 65536) % 65536;
        if (d >= 32768) d = d - 65536;
        if (d >= 0) d = d / 8;
        else        d = -((-d + 7) / 8);
        return 16'(d);
    endfunction

    // Model state
    bit          m_primed;
    int          m_idle;
    int          m_cd;
    int          m_prev [3];
    logic [15:0] m_res  [3];
    logic [15:0] exp_dx, exp_dy, exp_dz;
    bit          exp_rv, exp_rdy;

    always @(posedge CLK) begin
        started = 1;
        if (RST) begin
            m_primed = 0; m_idle = 0; m_cd = 0;
            m_prev[0] = 0; m_prev[1] = 0; m_prev[2] = 0;
            exp_dx = '0; exp_dy = '0; exp_dz = '0;
            exp_rv = 0; exp_rdy = 1;
        end else if (exp_rdy) begin
            if (tilt_valid) begin
                if (m_primed) begin
                    m_res[0] = ref_rate(int'(tilt_x), m_prev[0]);
                    m_res[1] = ref_rate(int'(tilt_y), m_prev[1]);
                    m_res[2] = ref_rate(int'(tilt_z), m_prev[2]);
                    m_cd = 3;
                    exp_rdy = 0;
                end
                m_prev[0] = int'(tilt_x);
                m_prev[1] = int'(tilt_y);
                m_prev[2] = int'(tilt_z);
                m_primed = 1;
                m_idle = 0;
            end else if (m_primed) begin
                m_idle++;
                if (m_idle == 50) begin
                    m_primed = 0;
                    m_idle = 0;
                end
            end
        end else if (m_cd > 0) begin
            m_cd--;
            if (m_cd == 0) begin
                exp_dx = m_res[0]; exp_dy = m_res[1]; exp_dz = m_res[2];
                exp_rv = 1;
            end
        end else if (exp_rv && rate_ready) begin
            exp_rv = 0;
            exp_rdy = 1;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge CLK) begin
        if (started) begin
            check("rate_valid", rate_valid, exp_rv);
            check("tilt_ready", tilt_ready, exp_rdy);
            check("dx", dx, exp_dx);
            check("dy", dy, exp_dy);
            check("dz", dz, exp_dz);
        end
    end

    // Caller is at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        tilt_x = x; tilt_y = y; tilt_z = z;
        tilt_valid = 1'b1;
        @(negedge CLK);
        tilt_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!rate_valid && n < 12) begin
            @(negedge CLK);
            n++;
        end
        check("wait_valid", rate_valid, 1'b1);
    endtask

    task automatic ack();
        rate_ready = 1'b1;
        @(negedge CLK);
        rate_ready = 1'b0;
    endtask

    task automatic txn(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        send(x, y, z);
        wait_valid();
    endtask

    initial begin
        RST = 1'b1; tilt_valid = 1'b0; rate_ready = 1'b0;
        tilt_x = '0; tilt_y = '0; tilt_z = '0;
        @(negedge CLK);
        @(negedge CLK);
        check("rst_dx", dx, 16'h0);
        check("rst_rv", rate_valid, 1'b0);
        check("rst_rdy", tilt_ready, 1'b1);
        RST = 1'b0;
        @(negedge CLK);

        // Prime only
        send(16'd100, 16'd200, 16'd300);
        check("prime_rv", rate_valid, 1'b0);
        check("prime_rdy", tilt_ready, 1'b1);

        // First rate with latency of three edges
        send(16'd180, 16'd200, 16'd260);
        check("lat_n1", rate_valid, 1'b0);
        @(negedge CLK);
        check("lat_n2", rate_valid, 1'b0);
        @(negedge CLK);
        check("lat_n3", rate_valid, 1'b0);
        @(negedge CLK);
        check("lat_valid", rate_valid, 1'b1);
        check("t2_dx", dx, 16'd10);
        check("t2_dy", dy, 16'd0);
        check("t2_dz", dz, 16'hFFFB);
        check("model_dz", exp_dz, 16'hFFFB);
        ack();
        check("ack_rv", rate_valid, 1'b0);
        check("ack_rdy", tilt_ready, 1'b1);

        // Wrap-around across signed and unsigned boundaries
        txn(16'h7FF0, 16'd200, 16'd260); ack();
        txn(16'h8010, 16'd199, 16'd260);
        check("wrap1_dx", dx, 16'd4);
        check("wrap1_dy", dy, 16'hFFFF);
        check("model_dx", exp_dx, 16'd4);
        ack();
        txn(16'hFFF8, 16'd199, 16'd260); ack();
        txn(16'h0008, 16'd199, 16'd276);
        check("wrap2_dx", dx, 16'd2);
        check("wrap2_dz", dz, 16'd2);
        ack();

        // Back-pressure: hold for 10 cycles while a new sample is offered
        txn(16'h0010, 16'd199, 16'd276);
        tilt_x = 16'h4000; tilt_y = 16'h4000; tilt_z = 16'h4000;
        tilt_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            check("hold_rv", rate_valid, 1'b1);
            check("hold_dx", dx, 16'd1);
            check("hold_rdy", tilt_ready, 1'b0);
        end
        tilt_valid = 1'b0;
        ack();
        check("hold_ack_rv", rate_valid, 1'b0);

        // Timeout: 50 idle cycles return to priming
        repeat (50) @(negedge CLK);
        send(16'd500, 16'd500, 16'd500);
        repeat (5) @(negedge CLK);
        check("tmo_prime_rv", rate_valid, 1'b0);
        check("tmo_prime_rdy", tilt_ready, 1'b1);
        txn(16'd516, 16'd500, 16'd492);
        check("tmo_dx", dx, 16'd2);
        check("tmo_dz", dz, 16'hFFFF);
        ack();

        // Accept on exactly the 50th idle cycle wins over timeout
        repeat (49) @(negedge CLK);
        txn(16'd532, 16'd500, 16'd500);
        check("edge_dx", dx, 16'd2);
        check("edge_dz", dz, 16'd1);
        ack();

        // Reset during CALC_Y
        send(16'd1000, 16'd2000, 16'd3000);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("rstmid_dx", dx, 16'h0);
        check("rstmid_dz", dz, 16'h0);
        check("rstmid_rv", rate_valid, 1'b0);
        check("rstmid_rdy", tilt_ready, 1'b1);
        send(16'd1000, 16'd2000, 16'd3000);
        repeat (5) @(negedge CLK);
        check("rstmid_prime_rv", rate_valid, 1'b0);
        txn(16'd1064, 16'd1992, 16'd3000);
        check("rstmid_dx2", dx, 16'd8);
        check("rstmid_dy2", dy, 16'hFFFF);
        check("rstmid_dz2", dz, 16'd0);
        ack();
        @(negedge CLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
